// File: rtl/int_vec_alu.sv
// int_vec_alu: bus-mapped lane-wise integer vector ALU with a multi-cycle engine.
//
// Ports:
//   Clk        system clock, rising edge
//   nReset     asynchronous active-low reset
//   address    [15:12] module select (== MODULE_ID), [11:0] register offset
//   nWrite     active-low write strobe
//   nRead      active-low read strobe
//   DataIn     write data (BUS_W bits)
//   DataOut    registered read data, 0 when not read-selected
//   ResultOut  live copy of the RESULT register
//   Busy       operation in progress
//   Done       sticky completion flag, cleared by the next accepted start
//
// Register map: 0 SRC1, 1 SRC2, 2 RESULT, 3 CTRL (write = start), 4 STATUS.
// Optional feature: define INT_VEC_ALU_SAT_EN for unsigned saturating arithmetic
// (STATUS bit4 reports saturation in the last operation); otherwise modulo wrap.

module int_vec_alu #(
    parameter int unsigned LANE_W    = 16,
    parameter int unsigned LANES     = 16,
    parameter logic [3:0]  MODULE_ID = 4'd5,
    localparam int unsigned BUS_W    = LANE_W * LANES
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic [15:0]      address,
    input  logic             nWrite,
    input  logic             nRead,
    input  logic [BUS_W-1:0] DataIn,
    output logic [BUS_W-1:0] DataOut,
    output logic [BUS_W-1:0] ResultOut,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

`ifdef INT_VEC_ALU_SAT_EN
    // Extra headroom bits expose carry/borrow/overflow for clamping
    localparam int unsigned SUM_W  = LANE_W + 1;
    localparam int unsigned PROD_W = 2 * LANE_W;
    localparam int unsigned ACC_W  = 2 * LANE_W + 1;
`else
    localparam int unsigned SUM_W  = LANE_W;
    localparam int unsigned PROD_W = LANE_W;
    localparam int unsigned ACC_W  = LANE_W;
`endif

    localparam logic [7:0]  OP_ADD   = 8'h10;
    localparam logic [7:0]  OP_SUB   = 8'h11;
    localparam logic [7:0]  OP_CONV  = 8'h12;
    localparam logic [7:0]  OP_LMUL  = 8'h13;
    localparam logic [7:0]  OP_SCALE = 8'h14;

    localparam logic [11:0] OFF_SRC1   = 12'd0;
    localparam logic [11:0] OFF_SRC2   = 12'd1;
    localparam logic [11:0] OFF_RESULT = 12'd2;
    localparam logic [11:0] OFF_CTRL   = 12'd3;
    localparam logic [11:0] OFF_STATUS = 12'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [BUS_W-1:0]   r_src1;
    logic [BUS_W-1:0]   r_src2;
    logic [BUS_W-1:0]   r_result;
    logic [BUS_W-1:0]   r_op1;
    logic [BUS_W-1:0]   r_op2;
    logic [BUS_W-1:0]   r_acc;
    logic [BUS_W-1:0]   r_dout;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_opcode;
    logic               r_busy;
    logic               r_done;
    logic               r_err_ill;
    logic               r_err_wwb;

    logic               w_sel;
    logic               w_wr;
    logic               w_rd;
    logic [11:0]        w_off;
    logic               w_wr_src;
    logic               w_wr_ctrl;
    logic               w_wr_stat;
    logic               w_op_legal;
    logic               w_idle;
    logic               w_start;
    logic               w_is_addsub;
    logic               w_last;
    logic               w_run_done;
    logic               w_sat_bit;
    logic [15:0]        w_status;
    logic [BUS_W-1:0]   w_rd_data;
    logic [31:0]        w_sh;
    logic [BUS_W-1:0]   w_b_shl;

    logic [LANE_W-1:0]  w_a_i;
    logic [LANE_W-1:0]  w_a_k;
    logic [LANE_W-1:0]  w_b_k;
    logic [LANE_W-1:0]  w_acc_k;
    logic [LANE_W-1:0]  w_m;
    logic [SUM_W-1:0]   w_sum;
    logic [SUM_W-1:0]   w_dif;
    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W-1:0]   w_accsum;
    logic [LANE_W-1:0]  w_add_l;
    logic [LANE_W-1:0]  w_sub_l;
    logic [LANE_W-1:0]  w_mul_l;
    logic [LANE_W-1:0]  w_mac_l;
    logic [BUS_W-1:0]   w_vec_res;
    logic [BUS_W-1:0]   w_acc_nxt;

`ifdef INT_VEC_ALU_SAT_EN
    logic               r_sat;
    logic               w_vec_sat;
    logic               w_mul_sat;
    assign w_sat_bit = r_sat;
`else
    assign w_sat_bit = 1'b0;
`endif

    // Bus decode
    assign w_sel       = (address[15:12] == MODULE_ID);
    assign w_wr        = w_sel & ~nWrite;
    assign w_rd        = w_sel & ~nRead;
    assign w_off       = address[11:0];
    assign w_wr_src    = w_wr & ((w_off == OFF_SRC1) | (w_off == OFF_SRC2));
    assign w_wr_ctrl   = w_wr & (w_off == OFF_CTRL);
    assign w_wr_stat   = w_wr & (w_off == OFF_STATUS);
    assign w_op_legal  = (DataIn[7:0] >= OP_ADD) & (DataIn[7:0] <= OP_SCALE);
    assign w_idle      = (r_state == S_IDLE);
    assign w_start     = w_wr_ctrl & w_idle & w_op_legal;
    assign w_is_addsub = (r_opcode == OP_ADD) | (r_opcode == OP_SUB);
    assign w_last      = (r_cnt == CNT_W'(LANES - 1));
    assign w_run_done  = (r_state == S_RUN) & (w_is_addsub | w_last);

    assign w_status = {r_opcode, 3'b000, w_sat_bit, r_err_wwb, r_err_ill, r_done, r_busy};

    // b[k-i] lands in lane k once the operand is shifted up by i lanes
    assign w_sh    = 32'(r_cnt) * LANE_W;
    assign w_b_shl = r_op2 << w_sh;

    // Read data mux; CTRL is write-only and unmapped offsets read 0
    always_comb begin
        w_rd_data = '0;
        case (w_off)
            OFF_SRC1:   w_rd_data = r_src1;
            OFF_SRC2:   w_rd_data = r_src2;
            OFF_RESULT: w_rd_data = r_result;
            OFF_STATUS: w_rd_data = BUS_W'(w_status);
            default:    w_rd_data = '0;
        endcase
    end

    // Lane datapath: full-vector ADD/SUB and one source index per step for products
    always_comb begin
        w_a_i     = '0;
        w_a_k     = '0;
        w_b_k     = '0;
        w_acc_k   = '0;
        w_m       = '0;
        w_sum     = '0;
        w_dif     = '0;
        w_prod    = '0;
        w_accsum  = '0;
        w_add_l   = '0;
        w_sub_l   = '0;
        w_mul_l   = '0;
        w_mac_l   = '0;
        w_vec_res = '0;
        w_acc_nxt = r_acc;
`ifdef INT_VEC_ALU_SAT_EN
        w_vec_sat = 1'b0;
        w_mul_sat = 1'b0;
`endif
        for (int k = 0; k < LANES; k++) begin
            if (CNT_W'(k) == r_cnt) begin
                w_a_i = r_op1[k*LANE_W +: LANE_W];
            end
        end
        for (int k = 0; k < LANES; k++) begin
            w_a_k   = r_op1[k*LANE_W +: LANE_W];
            w_b_k   = r_op2[k*LANE_W +: LANE_W];
            w_acc_k = r_acc[k*LANE_W +: LANE_W];
            if (r_opcode == OP_CONV) begin
                w_m = w_b_shl[k*LANE_W +: LANE_W];
            end else if (r_opcode == OP_SCALE) begin
                w_m = r_op2[LANE_W-1:0];
            end else begin
                w_m = w_b_k;
            end
            w_sum    = SUM_W'(w_a_k) + SUM_W'(w_b_k);
            w_dif    = SUM_W'(w_a_k) - SUM_W'(w_b_k);
            w_prod   = PROD_W'(w_a_i) * PROD_W'(w_m);
            w_accsum = ACC_W'(w_acc_k) + ACC_W'(w_prod);
`ifdef INT_VEC_ALU_SAT_EN
            w_add_l = w_sum[SUM_W-1] ? {LANE_W{1'b1}} : w_sum[LANE_W-1:0];
            w_sub_l = w_dif[SUM_W-1] ? {LANE_W{1'b0}} : w_dif[LANE_W-1:0];
            w_mul_l = (|w_prod[PROD_W-1:LANE_W]) ? {LANE_W{1'b1}} : w_prod[LANE_W-1:0];
            w_mac_l = (|w_accsum[ACC_W-1:LANE_W]) ? {LANE_W{1'b1}} : w_accsum[LANE_W-1:0];
            w_vec_sat = w_vec_sat | ((r_opcode == OP_SUB) ? w_dif[SUM_W-1] : w_sum[SUM_W-1]);
            if (r_opcode == OP_CONV) begin
                w_mul_sat = w_mul_sat | (|w_accsum[ACC_W-1:LANE_W]);
            end else if (CNT_W'(k) == r_cnt) begin
                w_mul_sat = w_mul_sat | (|w_prod[PROD_W-1:LANE_W]);
            end
`else
            w_add_l = w_sum;
            w_sub_l = w_dif;
            w_mul_l = w_prod;
            w_mac_l = w_accsum;
`endif
            w_vec_res[k*LANE_W +: LANE_W] = (r_opcode == OP_SUB) ? w_sub_l : w_add_l;
            if (r_opcode == OP_CONV) begin
                w_acc_nxt[k*LANE_W +: LANE_W] = w_mac_l;
            end else if (CNT_W'(k) == r_cnt) begin
                w_acc_nxt[k*LANE_W +: LANE_W] = w_mul_l;
            end
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_run_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registers, bus side effects and engine datapath
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_src1    <= '0;
            r_src2    <= '0;
            r_result  <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_acc     <= '0;
            r_dout    <= '0;
            r_cnt     <= '0;
            r_opcode  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err_ill <= 1'b0;
            r_err_wwb <= 1'b0;
`ifdef INT_VEC_ALU_SAT_EN
            r_sat     <= 1'b0;
`endif
        end else begin
            // Read samples pre-write register contents
            r_dout <= w_rd ? w_rd_data : '0;
            r_busy <= (w_state_nxt == S_RUN);

            if (w_wr_stat) begin
                r_err_ill <= 1'b0;
                r_err_wwb <= 1'b0;
            end
            if ((w_wr_src | w_wr_ctrl) & ~w_idle) begin
                r_err_wwb <= 1'b1;
            end
            if (w_wr_ctrl & w_idle & ~w_op_legal) begin
                r_err_ill <= 1'b1;
            end
            if (w_wr & w_idle & (w_off == OFF_SRC1)) begin
                r_src1 <= DataIn;
            end
            if (w_wr & w_idle & (w_off == OFF_SRC2)) begin
                r_src2 <= DataIn;
            end

            if (w_start) begin
                r_op1    <= r_src1;
                r_op2    <= r_src2;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_opcode <= DataIn[7:0];
                r_done   <= 1'b0;
`ifdef INT_VEC_ALU_SAT_EN
                r_sat    <= 1'b0;
`endif
            end else if (r_state == S_RUN) begin
`ifdef INT_VEC_ALU_SAT_EN
                r_sat <= r_sat | (w_is_addsub ? w_vec_sat : w_mul_sat);
`endif
                if (w_is_addsub) begin
                    r_result <= w_vec_res;
                    r_done   <= 1'b1;
                end else begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= w_acc_nxt;
                        r_done   <= 1'b1;
                    end
                end
            end
        end
    end

    assign DataOut   = r_dout;
    assign ResultOut = r_result;
    assign Busy      = r_busy;
    assign Done      = r_done;

endmodule
